// File: rtl/i2s_dac_tx_if.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx_if
// Sample handshake between the amplitude stage (master) and the I2S DAC
// transmitter (slave).
//   sample_i        16-bit sample word
//   sample_valid_i  sample_i is valid this cycle
//   sample_ready_o  transmitter holding register is empty
// ---------------------------------------------------------------------------
interface i2s_dac_tx_if;
  logic [15:0] sample_i;
  logic        sample_valid_i;
  logic        sample_ready_o;

  modport master (
    output sample_i,
    output sample_valid_i,
    input  sample_ready_o
  );

  modport slave (
    input  sample_i,
    input  sample_valid_i,
    output sample_ready_o
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// i2s_dac_tx
// Serialises one 16-bit sample per audio frame into a mono I2S stream (same
// word on left and right) for the board DAC. BCLK, LRCK and SDATA are all
// derived from the single system clock.
//
// Parameters:
//   CLK_DIV        clk cycles per BCLK half-period (2..255)
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   smp            sample handshake (slave side of i2s_dac_tx_if)
//   mute_i         sampled at frame load; 1 sends an all-zero frame
//   bclk_o         I2S bit clock
//   lrck_o         word select, 0 = left, 1 = right
//   sdata_o        serial data, MSB first
//   underrun_o     one-clk pulse when a frame loads with no new sample
//   frame_start_o  one-clk pulse on every frame load
//
// Build option:
//   OFFSET_BINARY_EN  when defined the input is offset binary and its MSB is
//                     inverted at load to give two's complement; otherwise
//                     the sample passes through unchanged.
// ---------------------------------------------------------------------------
module i2s_dac_tx #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  i2s_dac_tx_if.slave smp,
  input  logic        mute_i,
  output logic        bclk_o,
  output logic        lrck_o,
  output logic        sdata_o,
  output logic        underrun_o,
  output logic        frame_start_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0]  div_cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [31:0] shift_r;
  logic [15:0] hold_r;
  logic [15:0] last_word_r;
  logic        hold_full_r;

  logic        div_tc_s;
  logic        fall_tick_s;
  logic        load_s;
  logic        accept_s;
  logic [4:0]  bit_cnt_nxt_s;
  logic [15:0] word_s;
  logic [31:0] frame_word_s;

  // Convert the held sample into the two's-complement word the DAC expects.
  function automatic logic [15:0] to_dac_word(input logic [15:0] s);
`ifdef OFFSET_BINARY_EN
    return {~s[15], s[14:0]};
`else
    return s;
`endif
  endfunction

  assign div_tc_s      = (div_cnt_r == DIV_LAST);
  // bclk_o is still high in the clk where it is about to fall
  assign fall_tick_s   = div_tc_s & bclk_o;
  assign bit_cnt_nxt_s = bit_cnt_r + 5'd1;
  assign load_s        = fall_tick_s & (bit_cnt_r == 5'd31);
  assign accept_s      = smp.sample_valid_i & ~hold_full_r;
  assign word_s        = to_dac_word(hold_r);

  assign smp.sample_ready_o = ~hold_full_r;

  // Choose the 32-bit frame presented to the shifter at frame load.
  always_comb begin
    frame_word_s = 32'd0;
    if (mute_i) begin
      frame_word_s = 32'd0;
    end else if (hold_full_r) begin
      frame_word_s = {word_s, word_s};
    end else begin
      frame_word_s = {last_word_r, last_word_r};
    end
  end

  // BCLK divider: toggle bclk at the terminal count of div_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= 8'd0;
      bclk_o    <= 1'b0;
    end else if (div_tc_s) begin
      div_cnt_r <= 8'd0;
      bclk_o    <= ~bclk_o;
    end else begin
      div_cnt_r <= div_cnt_r + 8'd1;
    end
  end

  // Bit position, word select and serial data all advance on BCLK falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= 5'd31;
      lrck_o    <= 1'b0;
      sdata_o   <= 1'b0;
      shift_r   <= 32'd0;
    end else if (fall_tick_s) begin
      bit_cnt_r <= bit_cnt_nxt_s;
      // LRCK switches one BCLK ahead of each channel's MSB
      lrck_o    <= (bit_cnt_nxt_s >= 5'd15) && (bit_cnt_nxt_s <= 5'd30);
      if (load_s) begin
        sdata_o <= frame_word_s[31];
        shift_r <= {frame_word_s[30:0], 1'b0};
      end else begin
        sdata_o <= shift_r[31];
        shift_r <= {shift_r[30:0], 1'b0};
      end
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // One-entry holding register. A load consumes the entry as it stood
  // before the edge, so an accept in the load clk waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r      <= 16'd0;
      hold_full_r <= 1'b0;
      last_word_r <= 16'd0;
    end else if (load_s && hold_full_r) begin
      hold_full_r <= 1'b0;
      // muted frames still update the repeat word
      last_word_r <= word_s;
    end else if (accept_s) begin
      hold_r      <= smp.sample_i;
      hold_full_r <= 1'b1;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  // Frame-load status pulses, one clk wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_o    <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      underrun_o    <= load_s & ~hold_full_r;
      frame_start_o <= load_s;
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_dac_tx
// Bench for i2s_dac_tx with CLK_DIV=2 (BCLK = 4 clk, frame = 128 clk).
// Expected frames are pushed to a scoreboard when stimulus is driven; a
// monitor rebuilds each transmitted frame from sdata/lrck at BCLK rises
// and compares it with the scoreboard head.
// ---------------------------------------------------------------------------
module tb_i2s_dac_tx;

  localparam int unsigned CLK_DIV = 2;
  localparam logic [31:0] LRCK_PATTERN = 32'h0001_FFFE;

  logic clk;
  logic rst_n;
  logic mute_i;
  logic bclk_o, lrck_o, sdata_o, underrun_o, frame_start_o;

  i2s_dac_tx_if smp_if ();

  i2s_dac_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .smp           (smp_if),
    .mute_i        (mute_i),
    .bclk_o        (bclk_o),
    .lrck_o        (lrck_o),
    .sdata_o       (sdata_o),
    .underrun_o    (underrun_o),
    .frame_start_o (frame_start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] frame;
    logic        ur;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [15:0] sample;
    logic        mute;
    logic [31:0] exp_frame;
    logic        exp_ur;
  } vec_t;

  exp_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int stray_ur = 0;

  // monitor state
  bit          mon_on = 1'b0;
  logic        mon_bclk_q = 1'b0;
  int          mon_idx = 0;
  logic [31:0] mon_data = 32'd0;
  logic [31:0] mon_lrck = 32'd0;
  logic        mon_ur = 1'b0;

  function automatic logic [15:0] conv(input logic [15:0] s);
`ifdef OFFSET_BINARY_EN
    return {~s[15], s[14:0]};
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] rep(input logic [15:0] s);
    return {conv(s), conv(s)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] f, input logic ur);
    exp_t e;
    e.frame = f;
    e.ur = ur;
    exp_q.push_back(e);
  endtask

  // Present a sample and hold valid until the handshake completes.
  task automatic send(input logic [15:0] s);
    int k;
    k = 0;
    smp_if.sample_i = s;
    smp_if.sample_valid_i = 1'b1;
    while (!smp_if.sample_ready_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("accept_in_time", 32'(k < 300), 32'd1);
    @(negedge clk);
    smp_if.sample_valid_i = 1'b0;
  endtask

  // Advance to the negedge in the clk of the next frame load.
  task automatic wait_load();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start_o && k < 300);
    check("load_seen", 32'(frame_start_o), 32'd1);
  endtask

  // Frame monitor and scoreboard checker.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_on = 1'b0;
        mon_bclk_q = 1'b0;
      end else begin
        if (underrun_o && !frame_start_o) stray_ur++;
        if (frame_start_o) begin
          mon_on = 1'b1;
          mon_idx = 0;
          mon_ur = underrun_o;
        end
        if (mon_on && bclk_o && !mon_bclk_q) begin
          mon_data = {mon_data[30:0], sdata_o};
          mon_lrck = {mon_lrck[30:0], lrck_o};
          mon_idx++;
          if (mon_idx == 32) begin
            exp_t e;
            mon_on = 1'b0;
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("frame_data", mon_data, e.frame);
              check("frame_underrun", 32'(mon_ur), 32'(e.ur));
              check("frame_lrck", mon_lrck, LRCK_PATTERN);
            end
          end
        end
        mon_bclk_q = bclk_o;
      end
    end
  end

  // Run-time guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t tv[8];

  initial begin
    tv[0] = '{1'b1, 16'hA5C3, 1'b0, rep(16'hA5C3), 1'b0};
    tv[1] = '{1'b0, 16'h0000, 1'b0, rep(16'hA5C3), 1'b1};
    tv[2] = '{1'b1, 16'h3333, 1'b1, 32'h0000_0000, 1'b0};
    tv[3] = '{1'b0, 16'h0000, 1'b0, rep(16'h3333), 1'b1};
    tv[4] = '{1'b1, 16'h8000, 1'b0, rep(16'h8000), 1'b0};
    tv[5] = '{1'b1, 16'h0000, 1'b0, rep(16'h0000), 1'b0};
    tv[6] = '{1'b0, 16'h0000, 1'b1, 32'h0000_0000, 1'b1};
    tv[7] = '{1'b1, 16'h7FFF, 1'b0, rep(16'h7FFF), 1'b0};

    rst_n = 1'b0;
    mute_i = 1'b0;
    smp_if.sample_i = 16'd0;
    smp_if.sample_valid_i = 1'b0;

    // Reset values, then first BCLK rise at clk 2, fall + load at clk 4.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({bclk_o, lrck_o, sdata_o, underrun_o, frame_start_o, smp_if.sample_ready_o}),
          32'd1);
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("startup_bclk", 32'(bclk_o), 32'(c == 2 || c == 3));
      check("startup_frame_start", 32'(frame_start_o), 32'(c == 4));
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven frames: one record per frame load.
    for (int i = 0; i < 8; i++) begin
      mute_i = tv[i].mute;
      if (tv[i].valid) send(tv[i].sample);
      push(tv[i].exp_frame, tv[i].exp_ur);
      wait_load();
      check("ready_after_load", 32'(smp_if.sample_ready_o), 32'd1);
    end
    mute_i = 1'b0;

    // Back-to-back: 0x2222 waits while 0x1111 is held.
    begin
      int ready_hi;
      int k;
      ready_hi = 0;
      k = 0;
      smp_if.sample_i = 16'h1111;
      smp_if.sample_valid_i = 1'b1;
      @(negedge clk);
      smp_if.sample_i = 16'h2222;
      push(rep(16'h1111), 1'b0);
      while (!frame_start_o && k < 300) begin
        if (smp_if.sample_ready_o) ready_hi++;
        @(negedge clk);
        k++;
      end
      check("ready_low_until_load", 32'(ready_hi), 32'd0);
      check("b2b_load_seen", 32'(frame_start_o), 32'd1);
      check("ready_in_load_clk", 32'(smp_if.sample_ready_o), 32'd1);
      push(rep(16'h2222), 1'b0);
      @(negedge clk);
      check("second_accepted", 32'(smp_if.sample_ready_o), 32'd0);
      smp_if.sample_valid_i = 1'b0;
      wait_load();
    end

    // Minimum latency: accept one clk before the load.
    repeat (126) @(negedge clk);
    send(16'h5555);
    push(rep(16'h5555), 1'b0);
    wait_load();

    // Accept in the load clk: this load underruns, sample goes next frame.
    repeat (127) @(negedge clk);
    smp_if.sample_i = 16'h4444;
    smp_if.sample_valid_i = 1'b1;
    push(rep(16'h5555), 1'b1);
    push(rep(16'h4444), 1'b0);
    @(negedge clk);
    check("load_with_accept", 32'(frame_start_o), 32'd1);
    check("accepted_in_load_clk", 32'(smp_if.sample_ready_o), 32'd0);
    smp_if.sample_valid_i = 1'b0;
    wait_load();

    // Reset in the middle of a frame (bit 20).
    repeat (81) @(negedge clk);
    check("lrck_at_bit20", 32'(lrck_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs",
          32'({bclk_o, lrck_o, sdata_o, underrun_o, frame_start_o, smp_if.sample_ready_o}),
          32'd1);
    check("pending_frames", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // last_word was cleared, so the first frame is zero with underrun
    push(32'h0000_0000, 1'b1);
    repeat (4) @(negedge clk);
    check("reload_timing", 32'(frame_start_o), 32'd1);
    repeat (130) @(negedge clk);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("stray_underrun", 32'(stray_ur), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
